// File: rtl/eth_link_pkg.sv
// ============================================================================
// eth_link_pkg: shared link-sequencer types, speed codes and status bit map.
// Revision: 1.0
// ============================================================================
`default_nettype none

package eth_link_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_RESTART   = 3'd1,
    ST_WAIT_LINK = 3'd2,
    ST_QUALIFY   = 3'd3,
    ST_UP        = 3'd4,
    ST_FLUSH     = 3'd5
  } link_state_t;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;
  localparam logic [1:0] SPEED_RSVD = 2'b11;

  localparam int SV_LINK_BIT   = 0;
  localparam int SV_SPEED_LSB  = 10;
  localparam int SV_SPEED_MSB  = 11;
  localparam int SV_DUPLEX_BIT = 12;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sgmii_link_ctrl.sv
// ============================================================================
// sgmii_link_ctrl: SGMII AN restart / link qualification / MAC reset sequencer.
// Build option: LINK_CTRL_AUTO_RESTART_EN enables the WAIT_LINK timeout restart.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sgmii_link_ctrl
  import eth_link_pkg::*;
#(
  parameter int RESTART_PULSE_CYCLES = 16,
  parameter int AN_TIMEOUT_CYCLES    = 2_000_000,
  parameter int LINK_UP_CYCLES       = 125_000,
  parameter int MAC_RESET_CYCLES     = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] status_vector,
  input  logic        sw_restart,
  input  logic        irq_ack,
  output logic        an_restart_config,
  output logic        speed_is_10_100,
  output logic        speed_is_100,
  output logic        mac_reset,
  output logic        link_up,
  output logic [1:0]  link_speed,
  output logic        full_duplex,
  output logic        irq,
  output logic [7:0]  restart_count
);

  localparam int CNT_MAX = max_int(max_int(RESTART_PULSE_CYCLES, AN_TIMEOUT_CYCLES),
                                   max_int(LINK_UP_CYCLES, MAC_RESET_CYCLES));
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  // Counter counts N-1 down to 0 so each timed state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(RESTART_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_UP    = CNT_W'(LINK_UP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_MAC   = CNT_W'(MAC_RESET_CYCLES - 1);
`ifdef LINK_CTRL_AUTO_RESTART_EN
  localparam logic [CNT_W-1:0] LD_TMO   = CNT_W'(AN_TIMEOUT_CYCLES - 1);
`endif

  logic             s_link_q;
  logic [1:0]       s_speed_q;
  logic             s_dup_q;
  link_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cand_q, cand_d;
  logic             an_q, an_d;
  logic             mac_rst_q, mac_rst_d;
  logic             up_q, up_d;
  logic [1:0]       speed_q, speed_d;
  logic             fd_q, fd_d;
  logic             sel_10_100_q, sel_100_q;
  logic             irq_q, irq_d;
  logic [7:0]       rc_q, rc_d;
  logic             cnt_zero;
  logic             unused_status;

  assign unused_status = ^{status_vector[15:13], status_vector[9:1]};
  assign cnt_zero      = (cnt_q == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_link_q     <= 1'b0;
      s_speed_q    <= SPEED_10;
      s_dup_q      <= 1'b0;
      state_q      <= ST_HOLD;
      cnt_q        <= LD_MAC;
      cand_q       <= SPEED_10;
      an_q         <= 1'b0;
      mac_rst_q    <= 1'b1;
      up_q         <= 1'b0;
      speed_q      <= SPEED_1000;
      fd_q         <= 1'b1;
      sel_10_100_q <= 1'b0;
      sel_100_q    <= 1'b0;
      irq_q        <= 1'b0;
      rc_q         <= 8'd0;
    end else begin
      s_link_q     <= status_vector[SV_LINK_BIT];
      s_speed_q    <= status_vector[SV_SPEED_MSB:SV_SPEED_LSB];
      s_dup_q      <= status_vector[SV_DUPLEX_BIT];
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      an_q         <= an_d;
      mac_rst_q    <= mac_rst_d;
      up_q         <= up_d;
      speed_q      <= speed_d;
      fd_q         <= fd_d;
      sel_10_100_q <= (speed_d != SPEED_1000);
      sel_100_q    <= (speed_d == SPEED_100);
      irq_q        <= irq_d;
      rc_q         <= rc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    if (sw_restart) begin
      state_d = ST_RESTART;
      cnt_d   = LD_PULSE;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (cnt_zero) begin
            state_d = ST_RESTART;
            cnt_d   = LD_PULSE;
          end else cnt_d = cnt_q - 1'b1;
        end
        ST_RESTART: begin
          if (cnt_zero) begin
            state_d = ST_WAIT_LINK;
`ifdef LINK_CTRL_AUTO_RESTART_EN
            cnt_d   = LD_TMO;
`endif
          end else cnt_d = cnt_q - 1'b1;
        end
        ST_WAIT_LINK: begin
          if (s_link_q && (s_speed_q != SPEED_RSVD)) begin
            state_d = ST_QUALIFY;
            cnt_d   = LD_UP;
            cand_d  = s_speed_q;
          end
`ifdef LINK_CTRL_AUTO_RESTART_EN
          else if (cnt_zero) begin
            state_d = ST_RESTART;
            cnt_d   = LD_PULSE;
          end else cnt_d = cnt_q - 1'b1;
`endif
        end
        ST_QUALIFY: begin
          // A reserved speed code is treated like loss of link.
          if (!s_link_q || (s_speed_q == SPEED_RSVD)) begin
            state_d = ST_WAIT_LINK;
`ifdef LINK_CTRL_AUTO_RESTART_EN
            cnt_d   = LD_TMO;
`endif
          end else if (s_speed_q != cand_q) begin
            cand_d = s_speed_q;
            cnt_d  = LD_UP;
          end else if (cnt_zero) begin
            state_d = ST_UP;
          end else cnt_d = cnt_q - 1'b1;
        end
        ST_UP: begin
          if (!s_link_q || (s_speed_q != speed_q)) begin
            state_d = ST_FLUSH;
            cnt_d   = LD_MAC;
          end
        end
        ST_FLUSH: begin
          if (cnt_zero) begin
            state_d = ST_WAIT_LINK;
`ifdef LINK_CTRL_AUTO_RESTART_EN
            cnt_d   = LD_TMO;
`endif
          end else cnt_d = cnt_q - 1'b1;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = LD_MAC;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so they align with state_q.
  always_comb begin
    an_d      = (state_d == ST_RESTART);
    mac_rst_d = (state_d != ST_UP);
    up_d      = (state_d == ST_UP);
    speed_d   = speed_q;
    fd_d      = fd_q;
    if ((state_q == ST_QUALIFY) && (state_d == ST_UP)) begin
      speed_d = s_speed_q;
      fd_d    = s_dup_q;
    end
    rc_d = rc_q;
    if ((state_d == ST_RESTART) && ((state_q != ST_RESTART) || sw_restart) && (rc_q != 8'hFF))
      rc_d = rc_q + 8'd1;
    irq_d = irq_q;
    if (up_d != up_q)  irq_d = 1'b1;
    else if (irq_ack)  irq_d = 1'b0;
  end

  assign an_restart_config = an_q;
  assign speed_is_10_100   = sel_10_100_q;
  assign speed_is_100      = sel_100_q;
  assign mac_reset         = mac_rst_q;
  assign link_up           = up_q;
  assign link_speed        = speed_q;
  assign full_duplex       = fd_q;
  assign irq               = irq_q;
  assign restart_count     = rc_q;

endmodule

`default_nettype wire

// File: doc/sgmii_link_ctrl.md
# sgmii_link_ctrl

Link-management sequencer for the SGMII Ethernet path, between the PCS/PMA core and the 1G MAC wrapper, all in the `clock` (userclk2, 125 MHz) domain. Drives auto-negotiation restarts, qualifies link-up from the PCS/PMA status vector, and latches the negotiated speed into the speed-select outputs. Holds the MAC in reset while the link is down or changing speed, and raises a CPU interrupt on every link-state change.

## Interface
Parameters:
- `RESTART_PULSE_CYCLES`, 16: width of the `an_restart_config` pulse.
- `AN_TIMEOUT_CYCLES`, 2_000_000: cycles in WAIT_LINK before an automatic AN restart (16 ms).
- `LINK_UP_CYCLES`, 125_000: cycles the link must be continuously stable before it is declared up (1 ms).
- `MAC_RESET_CYCLES`, 64: minimum MAC reset hold.

Ports:
- `clock`  in  1  userclk2 from PCS/PMA. Sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `status_vector`  in  16  PCS/PMA status. Bit 0 is link status, bits [11:10] are speed, bit 12 is duplex.
- `sw_restart`  in  1  single-cycle software request to restart auto-negotiation.
- `irq_ack`  in  1  single-cycle clear of `irq`.
- `an_restart_config`  out  1  AN restart pulse to PCS/PMA.
- `speed_is_10_100`  out  1  speed select to PCS/PMA.
- `speed_is_100`  out  1  speed select to PCS/PMA.
- `mac_reset`  out  1  active-high reset to the MAC.
- `link_up`  out  1  qualified link status.
- `link_speed`  out  2  latched speed code: 00 = 10M, 01 = 100M, 10 = 1G.
- `full_duplex`  out  1  latched from bit 12.
- `irq`  out  1  level interrupt, link-change sticky.
- `restart_count`  out  8  AN restarts issued. Saturates at 255.

## Operation
- `status_vector` is registered once (stage S) before any use. All outputs are registered.
- One down-counter `cnt` is shared by all states. Its width is `$clog2` of the largest parameter plus 1.
- States and transitions:
  - **HOLD**: `mac_reset`=1. Loads `MAC_RESET_CYCLES`. At 0 → RESTART.
  - **RESTART**: `an_restart_config`=1 for `RESTART_PULSE_CYCLES`. On entry, `restart_count`++ (saturating). At 0 → WAIT_LINK.
  - **WAIT_LINK**: `mac_reset`=1. Loads `AN_TIMEOUT_CYCLES`.
    - If S[0]=1 and S[11:10]≠11 → QUALIFY.
    - Else at 0 → RESTART (see Configuration).
  - **QUALIFY**: loads `LINK_UP_CYCLES`. Captures the candidate speed on entry.
    - S[0]=0 → WAIT_LINK.
    - S[11:10] differs from the candidate → reload the counter with the new candidate.
    - At 0 → UP. `link_speed`/`full_duplex` are latched from S, `mac_reset`=0, `link_up`=1.
  - **UP**:
    - S[0]=0 → FLUSH.
    - S[11:10]≠`link_speed` → FLUSH.
    - Duplex change alone is ignored.
  - **FLUSH**: `link_up`=0, `mac_reset`=1 for `MAC_RESET_CYCLES`, then → WAIT_LINK. No AN restart.
- `sw_restart` has highest priority. From any state it goes to RESTART, forcing `mac_reset`=1 and `link_up`=0.
- Speed selects are derived from the latched `link_speed`:
  - `speed_is_10_100` = (`link_speed`≠10).
  - `speed_is_100` = (`link_speed`==01).
  - They change only on QUALIFY→UP.
- `irq` is set on every `link_up` edge (rise or fall) and cleared by `irq_ack`. If set and ack occur in the same cycle, set wins.

## Timing
- Reset values:
  - State HOLD, `mac_reset`=1.
  - `an_restart_config`=0, `link_up`=0, `irq`=0, `restart_count`=0.
  - `link_speed`=10, `full_duplex`=1, so `speed_is_10_100`=0 and `speed_is_100`=0.
- Status-to-output latency is 2 edges: a bit-0 fall at edge N gives `link_up`=0 / `mac_reset`=1 after edge N+2.
- Link-up latency is 2 + `LINK_UP_CYCLES` edges after stable S.
- An S[0] glitch of one cycle inside QUALIFY restarts qualification from the full count.
- `reset_n` assertion mid-operation immediately forces all reset values, including `mac_reset`=1, asynchronously.
- Deassertion is synchronised externally; the block samples it directly.

## Configuration
- `LINK_CTRL_AUTO_RESTART_EN` defined: WAIT_LINK timeout → RESTART.
- Undefined:
  - The WAIT_LINK timeout is ignored, and the block waits indefinitely for link.
  - AN restarts occur only after reset or on `sw_restart`.
  - The timeout counter logic is not synthesised.

## Structure
- Shared package `eth_link_pkg` holds:
  - the state enum `link_state_t`;
  - speed-code constants `SPEED_10`, `SPEED_100`, `SPEED_1000`, `SPEED_RSVD`;
  - status-vector bit-index constants.
- No sub-module; a single flat FSM plus counter.

## Test plan
Use small parameters: pulse 4, timeout 100, up 20, MAC reset 8.
- Reset release, S=0x0000 → `an_restart_config` high for 4 cycles after HOLD, `restart_count`=1. After 100 idle cycles a second pulse is issued and `restart_count`=2; with the macro undefined, no second pulse appears.
- S=0x1801 (1G, FD, link) held → after 2+20 cycles `link_up`=1, `mac_reset`=0, `link_speed`=10, `speed_is_10_100`=0, `speed_is_100`=0, `irq`=1.
- From UP, S → 0x1401 (100M) → `link_up`=0 and `mac_reset`=1 after 2 edges with no AN pulse. It requalifies to `speed_is_10_100`=1, `speed_is_100`=1.
- In QUALIFY, drop S[0] for 1 cycle at count 5 → no `link_up`. A full 20 cycles are required after the glitch.
- `irq_ack` on the same cycle as a link-down event → `irq` remains 1. A later `irq_ack` alone clears it.
- `sw_restart` in UP → next cycle `mac_reset`=1, `link_up`=0, AN pulse issued. With `restart_count` preloaded to 255, it stays at 255.
